fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 92 +++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  typedef logic [31:0] word_t;

  localparam word_t INSTR_NOP = 32'h00000013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH = 2'd0;
  localparam fetch_state_t DRAIN = 2'd1;
  localparam fetch_state_t HOLD  = 2'd2;

  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Branch-redirect input, memory read bus and decode handshake of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic  branch_taken;
  word_t branch_target;
  logic  fetch_valid;
  logic  fetch_ready;
  word_t fetch_address;
  word_t fetch_rdata;
  logic  instr_valid;
  logic  instr_ready;
  word_t instr_data;
  word_t instr_pc;

  modport master (
    input  branch_taken, branch_target, fetch_ready, fetch_rdata, instr_ready,
    output fetch_valid, fetch_address, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output branch_taken, branch_target, fetch_ready, fetch_rdata, instr_ready,
    input  fetch_valid, fetch_address, instr_valid, instr_data, instr_pc
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one instruction read at a time and buffers the returned
// word for decode; branch redirects discard in-flight or buffered instructions.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter word_t RESET_ADDRESS = 32'h00000000
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.master bus
);

  fetch_state_t state, state_d;
  word_t        pc, pc_d;
  word_t        pending, pending_d;
  word_t        instr_q, instr_d;
  word_t        instr_pc_q, instr_pc_d;
  word_t        target;

  assign target = align_word(bus.branch_target);

  // Reset gates the handshakes combinationally so nothing leaks out mid-reset.
  assign bus.fetch_valid   = !reset && (state == FETCH || state == DRAIN);
  assign bus.fetch_address = pc;
  assign bus.instr_valid   = !reset && (state == HOLD);
  assign bus.instr_data    = instr_q;
  assign bus.instr_pc      = instr_pc_q;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pending_d  = pending;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state)
      FETCH: begin
        if (bus.branch_taken) begin
          // A request cannot be withdrawn, so a redirect without ready waits in DRAIN.
          if (bus.fetch_ready) begin
            pc_d = target;
          end else begin
            pending_d = target;
            state_d   = DRAIN;
          end
        end else if (bus.fetch_ready) begin
          instr_d    = bus.fetch_rdata;
          instr_pc_d = pc;
          pc_d       = pc + 32'd4;
          state_d    = HOLD;
        end
      end
      DRAIN: begin
        if (bus.branch_taken) begin
          pending_d = target;
        end
        if (bus.fetch_ready) begin
          pc_d    = bus.branch_taken ? target : pending;
          state_d = FETCH;
        end
      end
      HOLD: begin
        // Redirect wins over decode acceptance; the buffered word is dropped.
        if (bus.branch_taken) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_ADDRESS;
      pending    <= RESET_ADDRESS;
      instr_q    <= INSTR_NOP;
      instr_pc_q <= RESET_ADDRESS;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pending    <= pending_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus a randomized run against a queue-based fetch model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk;
  logic reset;
  logic reset_w;
  int   n_tests;
  int   n_fail;

  fetch_sequencer_if bus ();
  fetch_sequencer_if bus_w ();

  fetch_sequencer #(.RESET_ADDRESS(32'h00000000)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  fetch_sequencer #(.RESET_ADDRESS(32'hFFFFFFFC)) dut_w (
    .clk(clk), .reset(reset_w), .bus(bus_w.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image; addresses outside the directed program get a hashed word.
  function automatic word_t mem_word(input word_t a);
    if (a == 32'h0) return 32'h00A00093;
    if (a == 32'h4 || a == 32'h8) return 32'h00000013;
    return a ^ 32'h5A5A0003;
  endfunction

  assign bus.fetch_rdata   = mem_word(bus.fetch_address);
  assign bus_w.fetch_rdata = mem_word(bus_w.fetch_address);

  // Behavioural model: the address of the next/outstanding request, whether that
  // request is stale (redirected away), and at most one buffered {pc, word}.
  word_t       m_req;
  logic        m_stale;
  word_t       m_redirect;
  logic [63:0] m_buf[$];

  task automatic model_step(input logic rst, input logic tk, input word_t tgt,
                            input logic frdy, input logic irdy);
    word_t t;
    t = {tgt[31:2], 2'b00};
    if (rst) begin
      m_req   = 32'h0;
      m_stale = 1'b0;
      m_buf.delete();
    end else if (m_buf.size() != 0) begin
      if (tk) begin
        m_buf.delete();
        m_req = t;
      end else if (irdy) begin
        m_buf.delete();
      end
    end else if (m_stale) begin
      if (frdy) begin
        m_req   = tk ? t : m_redirect;
        m_stale = 1'b0;
      end else if (tk) begin
        m_redirect = t;
      end
    end else if (tk) begin
      if (frdy) begin
        m_req = t;
      end else begin
        m_stale    = 1'b1;
        m_redirect = t;
      end
    end else if (frdy) begin
      m_buf.push_back({m_req, mem_word(m_req)});
      m_req = m_req + 32'd4;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tk, input word_t tgt, input logic frdy, input logic irdy);
    bus.branch_taken  = tk;
    bus.branch_target = tgt;
    bus.fetch_ready   = frdy;
    bus.instr_ready   = irdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h00000700, 1'b1, 1'b1);
    next_cycle();
    next_cycle();
    n_tests++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fetch_valid got %b expected 0", bus.fetch_valid); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_instr_valid got %b expected 0", bus.instr_valid); end
    n_tests++; if (bus.instr_data !== INSTR_NOP) begin n_fail++; $display("[TB] FAIL reset_instr_data got %h expected %h", bus.instr_data, INSTR_NOP); end
    n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr_pc got %h expected 0", bus.instr_pc); end
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    n_tests++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_req_valid got %b expected 1", bus.fetch_valid); end
    n_tests++; if (bus.fetch_address !== 32'h0) begin n_fail++; $display("[TB] FAIL first_req_addr got %h expected 0", bus.fetch_address); end
  endtask

  task automatic test_sequential();
    word_t exp_data;
    for (int k = 0; k < 3; k++) begin
      exp_data = (k == 0) ? 32'h00A00093 : 32'h00000013;
      n_tests++; if (bus.fetch_valid !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_fetch_phase[%0d] got fv=%b iv=%b expected fv=1 iv=0", k, bus.fetch_valid, bus.instr_valid); end
      n_tests++; if (bus.fetch_address !== word_t'(4 * k)) begin n_fail++; $display("[TB] FAIL seq_addr[%0d] got %h expected %h", k, bus.fetch_address, 4 * k); end
      next_cycle();
      n_tests++; if (bus.instr_valid !== 1'b1 || bus.fetch_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_hold_phase[%0d] got fv=%b iv=%b expected fv=0 iv=1", k, bus.fetch_valid, bus.instr_valid); end
      n_tests++; if (bus.instr_pc !== word_t'(4 * k)) begin n_fail++; $display("[TB] FAIL seq_pc[%0d] got %h expected %h", k, bus.instr_pc, 4 * k); end
      n_tests++; if (bus.instr_data !== exp_data) begin n_fail++; $display("[TB] FAIL seq_data[%0d] got %h expected %h", k, bus.instr_data, exp_data); end
      next_cycle();
    end
  endtask

  task automatic test_redirect_hold();
    next_cycle();
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000000C) begin n_fail++; $display("[TB] FAIL hold_entry got iv=%b pc=%h expected iv=1 pc=0000000c", bus.instr_valid, bus.instr_pc); end
    applyStimulus(1'b1, 32'h00000103, 1'b1, 1'b1);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    n_tests++; if (bus.fetch_address !== 32'h00000100 || bus.fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_redirect_addr got %h fv=%b expected 00000100 fv=1", bus.fetch_address, bus.fetch_valid); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_redirect_drop got iv=%b expected 0", bus.instr_valid); end
    next_cycle();
    n_tests++; if (bus.instr_pc !== 32'h00000100 || bus.instr_data !== mem_word(32'h100)) begin n_fail++; $display("[TB] FAIL hold_redirect_next got pc=%h data=%h expected 00000100 %h", bus.instr_pc, bus.instr_data, mem_word(32'h100)); end
    next_cycle();
  endtask

  task automatic test_redirect_stall();
    applyStimulus(1'b1, 32'h00000200, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus.fetch_ready = 1'b1;
      n_tests++; if (bus.fetch_valid !== 1'b1 || bus.fetch_address !== 32'h00000104) begin n_fail++; $display("[TB] FAIL stall_addr[%0d] got fv=%b addr=%h expected fv=1 addr=00000104", k, bus.fetch_valid, bus.fetch_address); end
      n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_iv[%0d] got %b expected 0", k, bus.instr_valid); end
      next_cycle();
    end
    bus.fetch_ready = 1'b0;
    n_tests++; if (bus.fetch_address !== 32'h00000200 || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_redirect got addr=%h iv=%b expected 00000200 iv=0", bus.fetch_address, bus.instr_valid); end
  endtask

  task automatic test_double_redirect();
    applyStimulus(1'b1, 32'h00000280, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(1'b1, 32'h00000300, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(1'b1, 32'h00000400, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    n_tests++; if (bus.fetch_address !== 32'h00000200 || bus.fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_stable got addr=%h fv=%b expected 00000200 fv=1", bus.fetch_address, bus.fetch_valid); end
    next_cycle();
    bus.fetch_ready = 1'b0;
    n_tests++; if (bus.fetch_address !== 32'h00000400 || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_latest got addr=%h iv=%b expected 00000400 iv=0", bus.fetch_address, bus.instr_valid); end
  endtask

  task automatic test_reset_in_drain();
    applyStimulus(1'b1, 32'h00000500, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    n_tests++; if (bus.fetch_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_reset_outputs got fv=%b iv=%b expected 0 0", bus.fetch_valid, bus.instr_valid); end
    next_cycle();
    reset = 1'b0;
    #1;
    n_tests++; if (bus.fetch_valid !== 1'b1 || bus.fetch_address !== 32'h0) begin n_fail++; $display("[TB] FAIL drain_reset_restart got fv=%b addr=%h expected 1 00000000", bus.fetch_valid, bus.fetch_address); end
    bus.fetch_ready = 1'b1;
    next_cycle();
    n_tests++; if (bus.instr_pc !== 32'h0 || bus.instr_data !== 32'h00A00093) begin n_fail++; $display("[TB] FAIL drain_reset_first got pc=%h data=%h expected 00000000 00a00093", bus.instr_pc, bus.instr_data); end
  endtask

  task automatic test_wrap();
    reset_w = 1'b1;
    next_cycle();
    reset_w = 1'b0;
    #1;
    n_tests++; if (bus_w.fetch_valid !== 1'b1 || bus_w.fetch_address !== 32'hFFFFFFFC) begin n_fail++; $display("[TB] FAIL wrap_first got fv=%b addr=%h expected 1 fffffffc", bus_w.fetch_valid, bus_w.fetch_address); end
    next_cycle();
    n_tests++; if (bus_w.instr_pc !== 32'hFFFFFFFC) begin n_fail++; $display("[TB] FAIL wrap_pc got %h expected fffffffc", bus_w.instr_pc); end
    next_cycle();
    n_tests++; if (bus_w.fetch_address !== 32'h0 || bus_w.fetch_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_next got addr=%h fv=%b expected 00000000 1", bus_w.fetch_address, bus_w.fetch_valid); end
  endtask

  task automatic test_random();
    logic  tk, frdy, irdy, rst;
    word_t tgt;
    logic  m_fv, m_iv;
    reset = 1'b1;
    model_step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst  = ($urandom_range(0, 49) == 0);
      tk   = ($urandom_range(0, 3) == 0);
      tgt  = $urandom;
      frdy = ($urandom_range(0, 2) != 0);
      irdy = ($urandom_range(0, 1) != 0);
      reset = rst;
      applyStimulus(tk, tgt, frdy, irdy);
      #1;
      m_fv = !rst && (m_buf.size() == 0);
      m_iv = !rst && (m_buf.size() != 0);
      n_tests++; if (bus.fetch_valid !== m_fv || bus.instr_valid !== m_iv) begin n_fail++; $display("[TB] FAIL rand_valid[%0d] got fv=%b iv=%b expected fv=%b iv=%b", cyc, bus.fetch_valid, bus.instr_valid, m_fv, m_iv); end
      if (m_fv) begin
        n_tests++; if (bus.fetch_address !== m_req) begin n_fail++; $display("[TB] FAIL rand_addr[%0d] got %h expected %h", cyc, bus.fetch_address, m_req); end
      end
      if (m_iv) begin
        n_tests++; if ({bus.instr_pc, bus.instr_data} !== m_buf[0]) begin n_fail++; $display("[TB] FAIL rand_instr[%0d] got %h/%h expected %h/%h", cyc, bus.instr_pc, bus.instr_data, m_buf[0][63:32], m_buf[0][31:0]); end
      end
      model_step(rst, tk, tgt, frdy, irdy);
      next_cycle();
    end
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    reset_w = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    bus_w.branch_taken  = 1'b0;
    bus_w.branch_target = 32'h0;
    bus_w.fetch_ready   = 1'b1;
    bus_w.instr_ready   = 1'b1;
    test_reset();
    test_sequential();
    test_redirect_hold();
    test_redirect_stall();
    test_double_redirect();
    test_reset_in_drain();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
